bd2b_seq: RTL and testbench
===========================

Name: bd2b_seq

Overview:
- Sequential BCD-to-binary converter; inverse of the binary-to-BCD path feeding the 7-segment display chain.
- Converts a packed DIGITS-digit BCD value (hundreds:tens:units by default) to an unsigned binary word.
- Uses reverse double-dabble: one shift-right plus digit correction per clock, with a start/busy/done handshake and an invalid-digit error flag.

Parameters:
- DIGITS, 3, number of packed BCD digits; bcd_in width is 4*DIGITS.
- BIN_W, 10, binary output width.
  - Must satisfy 2^BIN_W >= 10^DIGITS.
  - This is also the number of shift cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; [3:0] is units, [7:4] is tens, [11:8] is hundreds.
- busy  output  1  high while state is CONV.
- done  output  1  one-cycle pulse marking result/err valid.
- err  output  1  high when the last accepted bcd_in had a digit > 9.
- bin_out  output  BIN_W  converted value; held until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - busy=0, done=0, err=0, bin_out=0.
  - Shift register and cycle counter cleared.
  - Takes effect immediately, including mid-conversion; any partial result is discarded.
- States: IDLE, CONV, DONE.
- IDLE:
  - On a rising edge with start=1, latch bcd_in and check every digit.
  - If any digit > 9: go to DONE; set err=1, bin_out=0.
  - Otherwise:
    - Load working register {bcd_reg, bin_reg} = {bcd_in, BIN_W'b0}.
    - Set counter=BIN_W, err=0.
    - Go to CONV.
- CONV, each edge:
  - Shift {bcd_reg, bin_reg} right by 1; the bcd_reg LSB enters the bin_reg MSB.
  - Then, for each 4-bit digit of the shifted bcd_reg: if value >= 8, subtract 3 (4-bit arithmetic, no borrow between digits).
  - Decrement the counter.
  - On the edge where the counter goes 1->0: bin_out <= shifted bin_reg, state -> DONE.
- DONE:
  - done=1 for exactly one cycle; next edge returns to IDLE, done=0.
  - start is ignored in DONE.
- Latency (start sampled at edge E0):
  - Valid input: shifts at E1..E10 (BIN_W=10); done=1 between E10 and E11.
  - Invalid input: done=1 between E1 and E2.
- busy is 1 exactly while state=CONV. start is ignored while busy; bcd_in may change freely after E0.
- bin_out and err hold their values through IDLE until the next accepted start.
  - err is cleared or updated only when a new start is accepted.
- done, busy and err are registered outputs with no combinational path from inputs.
- Boundary values:
  - Input 0 gives 0.
  - Maximum 0x999 gives 999 (10'h3E7) with no overflow.
  - Digit value 0xA or above in any position gives err.

Test Plan:
- Reset, then start with bcd_in=12'h000 -> busy high 10 cycles; done pulse with bin_out=0, err=0.
- bcd_in=12'h255 -> done 10 cycles after start; bin_out=255; a second start with 12'h128 -> bin_out=128.
- bcd_in=12'h999 -> bin_out=999 (10'h3E7), err=0.
- bcd_in=12'h2A5 -> done 1 cycle after start; err=1, bin_out=0. A following valid start clears err.
- start re-asserted and bcd_in changed during CONV -> ignored; result matches the originally latched value.
- rst_n pulsed low mid-conversion -> all outputs 0 immediately; no done pulse. Exhaustive sweep of 000..999 -> bin_out equals decimal value for every input.

Source files
------------

// File: rtl/bd2b_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// One right shift plus per-digit correction per clock; start/busy/done handshake.
module bd2b_seq #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_out_q, bin_out_d;
  logic              err_q, err_d;

  logic                  digit_bad;
  logic [BcdW+BIN_W-1:0] work_sh;
  logic [BcdW-1:0]       bcd_fix;
  logic [BIN_W-1:0]      bin_sh;

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // Shift the whole working register right; bcd LSB falls into bin MSB.
  assign work_sh = {bcd_q, bin_q} >> 1;
  assign bin_sh  = work_sh[BIN_W-1:0];

  always_comb begin
    bcd_fix = work_sh[BcdW+BIN_W-1:BIN_W];
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_fix[4*i +: 4] >= 4'd8) bcd_fix[4*i +: 4] = bcd_fix[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          bcd_d = bcd_in;
          if (digit_bad) begin
            err_d     = 1'b1;
            bin_out_d = '0;
            state_d   = StDone;
          end else begin
            bin_d   = '0;
            cnt_d   = CntW'(BIN_W);
            err_d   = 1'b0;
            state_d = StConv;
          end
        end
      end
      StConv: begin
        bcd_d = bcd_fix;
        bin_d = bin_sh;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          bin_out_d = bin_sh;
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  assign busy    = (state_q == StConv);
  assign done    = (state_q == StDone);
  assign err     = err_q;
  assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bd2b_seq.sv
// Bench for bd2b_seq: directed and random conversions against an arithmetic model.
module tb_bd2b_seq;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [11:0]       bcd_in = '0;
  logic              busy, done, err;
  logic [BIN_W-1:0]  bin_out;

  int checks = 0;
  int errors = 0;
  int unsigned ref_bin = 0;
  bit ref_err = 1'b0;

  always #5 clk = ~clk;

  bd2b_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit bcd_ok(input logic [11:0] v);
    return (v[3:0] <= 9) && (v[7:4] <= 9) && (v[11:8] <= 9);
  endfunction

  function automatic int unsigned bcd_val(input logic [11:0] v);
    return 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int unsigned n);
    logic [11:0] r;
    r[11:8] = 4'((n / 100) % 10);
    r[7:4]  = 4'((n / 10) % 10);
    r[3:0]  = 4'(n % 10);
    return r;
  endfunction

  // One conversion; disturb re-asserts start with junk data while the DUT is not idle.
  task automatic conv(input logic [11:0] v, input bit disturb, input bit full);
    int unsigned exp_v;
    exp_v = bcd_val(v);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 12'($urandom);
    if (!bcd_ok(v)) begin
      ref_err = 1'b1;
      ref_bin = 0;
      check("inv_done", done, 1);
      check("inv_err", err, 1);
      check("inv_bin", bin_out, 0);
      if (full) check("inv_busy", busy, 0);
      if (disturb) begin
        start  = 1'b1;
        bcd_in = to_bcd($urandom_range(999));
      end
      @(negedge clk);
      start = 1'b0;
      check("inv_done_clr", done, 0);
      if (disturb) check("inv_ignore_busy", busy, 0);
      return;
    end
    ref_err = 1'b0;
    if (full) begin
      check("busy_e0", busy, 1);
      check("err_clr_e0", err, 0);
    end
    for (int c = 1; c < int'(BIN_W); c++) begin
      if (disturb && c >= 2 && c <= 7) begin
        start  = 1'b1;
        bcd_in = 12'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (full) begin
        check("busy_run", busy, 1);
        check("done_early", done, 0);
      end
    end
    @(negedge clk);
    ref_bin = exp_v;
    check("done_pulse", done, 1);
    check("bin_out", bin_out, ref_bin);
    check("err_ok", err, ref_err);
    if (full) begin
      check("busy_done", busy, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("bin_hold", bin_out, ref_bin);
    end
  endtask

  initial begin
    logic [11:0] v;
    rst_n = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_bin", bin_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    conv(12'h000, 1'b0, 1'b1);
    conv(12'h255, 1'b0, 1'b1);
    conv(12'h128, 1'b0, 1'b1);
    conv(12'h999, 1'b0, 1'b1);
    conv(12'h2A5, 1'b0, 1'b1);
    conv(12'h407, 1'b0, 1'b1);
    conv(12'h836, 1'b1, 1'b1);
    conv(12'hF00, 1'b1, 1'b1);
    conv(12'h00B, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      v = to_bcd($urandom_range(999));
      if ($urandom_range(3) == 0) begin
        int k;
        k = int'($urandom_range(2));
        v[4*k +: 4] = 4'(10 + $urandom_range(5));
      end
      conv(v, bit'($urandom_range(1)), 1'b1);
    end

    // Reset mid-conversion discards the partial result.
    conv(12'h0A0, 1'b0, 1'b0);
    conv(12'h777, 1'b0, 1'b0);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h456;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_bin", bin_out, 0);
    ref_bin = 0;
    ref_err = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      check("no_done_after_rst", done, 0);
    end
    check("bin_after_rst", bin_out, 0);

    for (int n = 0; n <= 999; n++) conv(to_bcd(n), 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
